ddr4_v2_2_20_cal_sync_filt: RTL and testbench
=============================================

DDR4_V2_2_20_CAL_SYNC_FILT -- requirements
Module: ddr4_v2_2_20_cal_sync_filt

Interface
REQ-001 SHALL have parameter SYNC_MTBF, default 2, synchronizer stage count; legal range 2..4.
REQ-002 SHALL have parameter WIDTH, default 8, independent channel count.
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, consecutive post-sync cycles a new level must persist before acceptance; minimum 1, where 1 means no filtering.
REQ-004 SHALL have parameter RESET_VAL, WIDTH bits, default all 0, per-channel reset level.
REQ-005 SHALL have parameter TCQ, default 100, sim-only clock-to-q delay in ps on every register.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port clk, input, 1 bit, sole clock.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port data_in, input, WIDTH bits, asynchronous level inputs.
REQ-010 SHALL have port data_out, output, WIDTH bits, synchronized and filtered levels.
REQ-011 SHALL have port rise, output, WIDTH bits, one-cycle pulse on each accepted 0->1 data_out transition.
REQ-012 SHALL have port fall, output, WIDTH bits, one-cycle pulse on each accepted 1->0 data_out transition.
REQ-013 SHALL have port stable, output, WIDTH bits, high when the synchronized sample equals data_out.

Function
REQ-014 Each channel SHALL shift data_in[wd] through a SYNC_MTBF-deep register chain every cycle, with dont_touch and ASYNC_REG attributes; s = the last stage.
REQ-015 Each channel SHALL hold a counter of width $clog2(FILTER_CYCLES+1) that saturates at FILTER_CYCLES-1.
REQ-016 At each edge where s == data_out, the counter SHALL clear to 0 and data_out SHALL hold.
REQ-017 At each edge where s != data_out and counter == FILTER_CYCLES-1, data_out SHALL take s, the counter SHALL clear, and rise or fall SHALL assert for exactly that one cycle.
REQ-018 At each edge where s != data_out and counter < FILTER_CYCLES-1, the counter SHALL increment.
REQ-019 Latency from a data_in change settling before edge 1 to data_out update SHALL be SYNC_MTBF+FILTER_CYCLES edges; with defaults, data_out changes after edge 6.
REQ-020 A pulse on s shorter than FILTER_CYCLES cycles SHALL produce no data_out change and no rise or fall pulse.
REQ-021 stable[wd] SHALL be combinational (s == data_out) from registers only.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on any subset of channels SHALL each be accepted per their own counters.
REQ-023 rise and fall SHALL never both be high on one channel in the same cycle.

Reset
REQ-024 While rst is high at an edge, sync chains and data_out SHALL load RESET_VAL, counters SHALL load 0, and rise and fall SHALL load 0.
REQ-025 Reset asserted mid-count SHALL discard the count; after release, a still-differing input SHALL require the full SYNC_MTBF+FILTER_CYCLES edges.
REQ-026 No rise or fall pulse SHALL occur on the first cycle after reset release caused by reset itself.

Configuration
REQ-027 With macro CAL_SYNC_EDGE_EN defined, rise and fall SHALL be registered pulses as specified above.
REQ-028 Without CAL_SYNC_EDGE_EN, rise and fall SHALL be constant 0, and no edge registers SHALL be built.

Structure
REQ-029 Package ddr4_v2_2_20_cal_sync_pkg SHALL hold the counter-width function, the SYNC_MTBF min/max constants and the FILTER_CYCLES minimum constant.
REQ-030 A per-channel sub-module ddr4_v2_2_20_cal_sync_filt_ch SHALL implement one sync chain, counter and edge logic; the top SHALL generate WIDTH instances.
REQ-031 The top SHALL flag illegal parameter values with an elaboration-time assertion.

Verification
REQ-032 Scenario 1: defaults, reset, data_in 0x00->0x01 held -> data_out[0]=1 after edge 6, rise[0] high one cycle, stable[0] low after edge 2 through edge 5.
REQ-033 Scenario 2: bit1 high for 3 cycles then low -> data_out, rise and fall unchanged at 0x00; stable[1] returns high.
REQ-034 Scenario 3: FILTER_CYCLES=1, SYNC_MTBF=3, bit2 rises -> data_out[2]=1 after edge 4.
REQ-035 Scenario 4: rst pulsed while bit0 count=2, input held high -> data_out[0]=0 during reset, then data_out[0]=1 six edges after release, single rise pulse.
REQ-036 Scenario 5: data_out settled at 0xFF, data_in=0x00 -> fall=0xFF for exactly one cycle, rise=0x00 throughout.
REQ-037 Scenario 6: build without CAL_SYNC_EDGE_EN, rerun scenario 5 -> rise=fall=0x00 always, data_out identical to scenario 5.

Source files
------------

// File: rtl/ddr4_v2_2_20_cal_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr4_v2_2_20_cal_sync_pkg
//  Description : Shared constants and helpers for the calibration
//                synchronizer/filter (legal parameter ranges, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr4_v2_2_20_cal_sync_pkg;

    localparam int SYNC_MTBF_MIN     = 2;
    localparam int SYNC_MTBF_MAX     = 4;
    localparam int FILTER_CYCLES_MIN = 1;

    // Width of the persistence counter; never narrower than one bit.
    function automatic int cnt_width(input int filter_cycles);
        if (filter_cycles < 1) begin
            return 1;
        end
        return (filter_cycles + 1 <= 2) ? 1 : $clog2(filter_cycles + 1);
    endfunction

endpackage : ddr4_v2_2_20_cal_sync_pkg
`default_nettype wire

// File: rtl/ddr4_v2_2_20_cal_sync_filt_ch.sv
`default_nettype none
// ============================================================================
//  Module      : ddr4_v2_2_20_cal_sync_filt_ch
//  Description : One channel: SYNC_MTBF-deep synchronizer followed by a
//                persistence filter. A new synchronized level is accepted only
//                after it has differed from data_out for FILTER_CYCLES edges.
//                Edge pulses are built only with CAL_SYNC_EDGE_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr4_v2_2_20_cal_sync_filt_ch
    import ddr4_v2_2_20_cal_sync_pkg::*;
#(
    parameter int   SYNC_MTBF     = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_out,
    output logic rise,
    output logic fall,
    output logic stable
);

    localparam int             CNT_W   = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [SYNC_MTBF-1:0] sync_q;

    logic             s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;

    assign s = sync_q[SYNC_MTBF-1];

    // Metastability chain: shift the raw level in one stage per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_MTBF{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_MTBF-2:0], data_in};
        end
    end

    // Filter decision: clear on agreement, accept at the count limit, else count.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (s == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            out_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign data_out = out_q;
    assign stable   = (s == out_q);

`ifdef CAL_SYNC_EDGE_EN
    logic accept;
    logic rise_q;
    logic fall_q;

    assign accept = (s != out_q) && (cnt_q == CNT_MAX);

    // One-cycle pulses aligned with the data_out update they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept &  s;
            fall_q <= accept & ~s;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : ddr4_v2_2_20_cal_sync_filt_ch
`default_nettype wire

// File: rtl/ddr4_v2_2_20_cal_sync_filt.sv
`default_nettype none
// ============================================================================
//  Module      : ddr4_v2_2_20_cal_sync_filt
//  Description : WIDTH independent synchronize-and-filter channels for
//                asynchronous calibration status levels.
//                Optional macro CAL_SYNC_EDGE_EN enables rise/fall pulses;
//                without it rise and fall are tied to zero.
//                TCQ is kept for interface compatibility; registers carry no
//                modelled clock-to-q delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr4_v2_2_20_cal_sync_filt
    import ddr4_v2_2_20_cal_sync_pkg::*;
#(
    parameter int               SYNC_MTBF     = 2,
    parameter int               WIDTH         = 8,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               TCQ           = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] stable
);

    // Reject configurations the channel logic cannot implement.
    if (SYNC_MTBF < SYNC_MTBF_MIN || SYNC_MTBF > SYNC_MTBF_MAX ||
        FILTER_CYCLES < FILTER_CYCLES_MIN || WIDTH < 1 || TCQ < 0) begin : g_param_check
        $error("ddr4_v2_2_20_cal_sync_filt: illegal parameter value");
    end

    for (genvar wd = 0; wd < WIDTH; wd++) begin : g_ch
        ddr4_v2_2_20_cal_sync_filt_ch #(
            .SYNC_MTBF     (SYNC_MTBF),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[wd])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in[wd]),
            .data_out (data_out[wd]),
            .rise     (rise[wd]),
            .fall     (fall[wd]),
            .stable   (stable[wd])
        );
    end

endmodule : ddr4_v2_2_20_cal_sync_filt
`default_nettype wire

// File: tb/tb_ddr4_v2_2_20_cal_sync_filt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr4_v2_2_20_cal_sync_filt
//  Description : Directed self-checking bench. Expectations for rise/fall
//                follow CAL_SYNC_EDGE_EN when defined, zero otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr4_v2_2_20_cal_sync_filt;

`ifdef CAL_SYNC_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [7:0] dout, rise, fall, stable;
    logic [7:0] din2;
    logic [7:0] dout2, rise2, fall2, stable2;

    int errors = 0;
    int checks = 0;

    ddr4_v2_2_20_cal_sync_filt dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (din),
        .data_out (dout),
        .rise     (rise),
        .fall     (fall),
        .stable   (stable)
    );

    ddr4_v2_2_20_cal_sync_filt #(
        .SYNC_MTBF     (3),
        .WIDTH         (8),
        .FILTER_CYCLES (1),
        .RESET_VAL     (8'h30)
    ) dut_fast (
        .clk      (clk),
        .rst      (rst),
        .data_in  (din2),
        .data_out (dout2),
        .rise     (rise2),
        .fall     (fall2),
        .stable   (stable2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one active edge and step off it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        din  = 8'h00;
        din2 = 8'h30;
        tick();
        tick();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want %h", dout, 8'h00); end
        checks++; if (rise !== 8'h00) begin errors++; $display("FAIL reset_rise: got %h want %h", rise, 8'h00); end
        checks++; if (fall !== 8'h00) begin errors++; $display("FAIL reset_fall: got %h want %h", fall, 8'h00); end
        checks++; if (stable !== 8'hFF) begin errors++; $display("FAIL reset_stable: got %h want %h", stable, 8'hFF); end
        checks++; if (dout2 !== 8'h30) begin errors++; $display("FAIL reset_dout2: got %h want %h", dout2, 8'h30); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ((rise | fall | rise2 | fall2) !== 8'h00) begin
                errors++; $display("FAIL post_reset_pulse: got %h want %h", rise | fall | rise2 | fall2, 8'h00);
            end
        end
    endtask

    task automatic test_basic_rise();
        logic [7:0] exp_out, exp_rise, exp_stab;
        din = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_out  = (e >= 6) ? 8'h01 : 8'h00;
            exp_rise = (EDGE_EN && e == 6) ? 8'h01 : 8'h00;
            exp_stab = (e >= 2 && e <= 5) ? 8'hFE : 8'hFF;
            checks++; if (dout !== exp_out) begin errors++; $display("FAIL basic_dout e%0d: got %h want %h", e, dout, exp_out); end
            checks++; if (rise !== exp_rise) begin errors++; $display("FAIL basic_rise e%0d: got %h want %h", e, rise, exp_rise); end
            checks++; if (fall !== 8'h00) begin errors++; $display("FAIL basic_fall e%0d: got %h want %h", e, fall, 8'h00); end
            checks++; if (stable !== exp_stab) begin errors++; $display("FAIL basic_stable e%0d: got %h want %h", e, stable, exp_stab); end
        end
    endtask

    task automatic test_glitch();
        din = 8'h03;
        tick(); tick(); tick();
        din = 8'h01;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (dout !== 8'h01 || rise !== 8'h00 || fall !== 8'h00) begin
                errors++; $display("FAIL glitch_filtered: got out=%h rise=%h fall=%h want out=01 rise=00 fall=00", dout, rise, fall);
            end
        end
        checks++; if (stable !== 8'hFF) begin errors++; $display("FAIL glitch_stable: got %h want %h", stable, 8'hFF); end
    endtask

    task automatic test_reset_midcount();
        logic [7:0] exp_out, exp_rise;
        din = 8'h00;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_preclear: got %h want %h", dout, 8'h00); end
        din = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_in_reset: got %h want %h", dout, 8'h00); end
        tick();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_in_reset2: got %h want %h", dout, 8'h00); end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_out  = (e >= 6) ? 8'h01 : 8'h00;
            exp_rise = (EDGE_EN && e == 6) ? 8'h01 : 8'h00;
            checks++; if (dout !== exp_out) begin errors++; $display("FAIL mid_dout e%0d: got %h want %h", e, dout, exp_out); end
            checks++; if (rise !== exp_rise) begin errors++; $display("FAIL mid_rise e%0d: got %h want %h", e, rise, exp_rise); end
        end
    endtask

    task automatic test_all_fall();
        logic [7:0] exp_out, exp_fall;
        din = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL fall_preset: got %h want %h", dout, 8'hFF); end
        din = 8'h00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_out  = (e >= 6) ? 8'h00 : 8'hFF;
            exp_fall = (EDGE_EN && e == 6) ? 8'hFF : 8'h00;
            checks++; if (dout !== exp_out) begin errors++; $display("FAIL fall_dout e%0d: got %h want %h", e, dout, exp_out); end
            checks++; if (fall !== exp_fall) begin errors++; $display("FAIL fall_fall e%0d: got %h want %h", e, fall, exp_fall); end
            checks++; if (rise !== 8'h00) begin errors++; $display("FAIL fall_rise e%0d: got %h want %h", e, rise, 8'h00); end
        end
    endtask

    task automatic test_fast_config();
        logic [7:0] exp_out, exp_rise;
        din2 = 8'h34;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_out  = (e >= 4) ? 8'h34 : 8'h30;
            exp_rise = (EDGE_EN && e == 4) ? 8'h04 : 8'h00;
            checks++; if (dout2 !== exp_out) begin errors++; $display("FAIL fast_dout e%0d: got %h want %h", e, dout2, exp_out); end
            checks++; if (rise2 !== exp_rise) begin errors++; $display("FAIL fast_rise e%0d: got %h want %h", e, rise2, exp_rise); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        din  = 8'h00;
        din2 = 8'h30;
        #2;
        test_reset();
        test_basic_rise();
        test_glitch();
        test_reset_midcount();
        test_all_fall();
        test_fast_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ddr4_v2_2_20_cal_sync_filt
`default_nettype wire
